state_dump: RTL and testbench

Debug dump sequencer sitting directly downstream of the single-cycle MIPS top level. It drives the top's debug read ports, `ReadReg` and `ReadMem`, and consumes `RegData` and `MemData`. On `Start`, it walks all architectural registers and then all data-memory words, and emits them as a tagged valid/ready word stream toward a UART/trace consumer. It never writes CPU state and does not stall the CPU.

---
 rtl/dump_pkg.sv | 18 +
 rtl/dump_out_reg.sv | 34 +++
 rtl/state_dump.sv | 170 +++++++++++++++++
 tb/tb_state_dump.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dump_pkg.sv
// Shared types and constants for the state_dump debug sequencer.
package dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REG,
        MEM,
        TRAIL,
        DRAIN
    } dump_state_t;

    localparam int         TAG_MEM_BIT   = 7;
    localparam logic [7:0] TAG_SUM       = 8'hFF;
    localparam int         DEF_REG_COUNT = 32;
    localparam int         DEF_MEM_WORDS = 64;
    localparam int         IDX_W         = 8;

endpackage

// File: rtl/dump_out_reg.sv
// Valid/ready holding register for one tagged dump word; exports the load strobe.
module dump_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill,
    input  logic [DATA_W-1:0] word_data,
    input  logic [7:0]        word_tag,
    input  logic              ready,
    output logic              load,
    output logic              valid,
    output logic [DATA_W-1:0] held_data,
    output logic [7:0]        held_tag
);

    // The register can take a new word whenever it is empty or being drained this cycle.
    assign load = !valid || ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            held_data <= '0;
            held_tag  <= '0;
        end else if (fill && load) begin
            valid     <= 1'b1;
            held_data <= word_data;
            held_tag  <= word_tag;
        end else if (valid && ready) begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/state_dump.sv
// Debug dump sequencer: streams all registers, then all memory words, as tagged words.
// Optional checksum trailer word is built when DUMP_CHECKSUM_EN is defined.
module state_dump
    import dump_pkg::*;
#(
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int MEM_WORDS = DEF_MEM_WORDS,
    parameter int DATA_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Start,
    output logic              Busy,
    output logic              Done,
    output logic [4:0]        ReadReg,
    input  logic [DATA_W-1:0] RegData,
    output logic [5:0]        ReadMem,
    input  logic [DATA_W-1:0] MemData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutData,
    output logic [7:0]        OutTag
);

    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

    dump_state_t      state;
    logic [IDX_W-1:0] idx;
    logic             start_pend;
    logic             fill;
    logic             load;
    logic             step;
    logic             accept_start;
    logic [DATA_W-1:0] cur_data;
    logic [7:0]        cur_tag;

`ifdef DUMP_CHECKSUM_EN
    logic [31:0] sum;
`endif

    assign ReadReg = (state == REG) ? idx[4:0] : 5'd0;
    assign ReadMem = (state == MEM) ? idx[5:0] : 6'd0;

    // A Start coinciding with Done is deliberately not accepted.
    assign accept_start = (state == IDLE) && Start && !start_pend && !Done;
    assign step         = fill && load;

    always_comb begin
        fill     = 1'b0;
        cur_data = '0;
        cur_tag  = '0;
        case (state)
            REG: begin
                fill     = 1'b1;
                cur_data = RegData;
                cur_tag  = {3'b000, idx[4:0]};
            end
            MEM: begin
                fill     = 1'b1;
                cur_data = MemData;
                cur_tag  = {2'b00, idx[5:0]};
                cur_tag[TAG_MEM_BIT] = 1'b1;
            end
`ifdef DUMP_CHECKSUM_EN
            TRAIL: begin
                fill     = 1'b1;
                cur_data = DATA_W'(sum);
                cur_tag  = TAG_SUM;
            end
`endif
            default: begin
                fill = 1'b0;
            end
        endcase
    end

    dump_out_reg #(
        .DATA_W(DATA_W)
    ) u_out (
        .clk       (CLK),
        .rst_n     (Reset),
        .fill      (fill),
        .word_data (cur_data),
        .word_tag  (cur_tag),
        .ready     (OutReady),
        .load      (load),
        .valid     (OutValid),
        .held_data (OutData),
        .held_tag  (OutTag)
    );

    // Start is registered into start_pend, so REG begins one edge after acceptance.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            idx        <= '0;
            start_pend <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Done) begin
                        Busy <= 1'b0;
                    end
                    if (start_pend) begin
                        state      <= REG;
                        idx        <= '0;
                        start_pend <= 1'b0;
                    end else if (accept_start) begin
                        start_pend <= 1'b1;
                        Busy       <= 1'b1;
                    end
                end
                REG: begin
                    if (step) begin
                        if (idx == REG_LAST) begin
                            state <= MEM;
                            idx   <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                MEM: begin
                    if (step) begin
                        idx <= idx + IDX_W'(1);
                        if (idx == MEM_LAST) begin
`ifdef DUMP_CHECKSUM_EN
                            state <= TRAIL;
`else
                            state <= DRAIN;
`endif
                        end
                    end
                end
                TRAIL: begin
                    if (step) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (OutValid && OutReady) begin
                        state <= IDLE;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Only register and memory words contribute; the trailer itself is excluded.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sum <= '0;
        end else if (accept_start) begin
            sum <= '0;
        end else if (step && (state == REG || state == MEM)) begin
            sum <= sum + 32'(cur_data);
        end
    end
`endif

endmodule

// File: tb/tb_state_dump.sv
// Self-checking bench for state_dump: reference stream built from register/memory arrays.
module tb_state_dump;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Busy;
    logic        Done;
    logic [4:0]  ReadReg;
    logic [31:0] RegData;
    logic [5:0]  ReadMem;
    logic [31:0] MemData;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] OutData;
    logic [7:0]  OutTag;

    logic [31:0] regs [32];
    logic [31:0] mem  [64];
    logic [31:0] last_data;
    logic [7:0]  last_tag;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign RegData = regs[ReadReg];
    assign MemData = mem[ReadMem];

    state_dump dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .Start    (Start),
        .Busy     (Busy),
        .Done     (Done),
        .ReadReg  (ReadReg),
        .RegData  (RegData),
        .ReadMem  (ReadMem),
        .MemData  (MemData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutTag   (OutTag)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high, 1: ready 1,0,0,1 repeating, 2: random ready.
    task automatic run_dump(input int mode, input bit poke);
        logic [31:0] ed[$];
        logic [7:0]  et[$];
        logic [31:0] sum;
        int s_edge, got, done_cnt, done_edge, after, i, nexp;
        bit rdy, prev_stall, busy_bad;
        logic [31:0] p_data;
        logic [7:0]  p_tag;
        logic [4:0]  p_rr;
        logic [5:0]  p_rm;
        sum = 32'd0;
        for (int k = 0; k < 32; k++) begin
            ed.push_back(regs[k]); et.push_back(8'(k)); sum += regs[k];
        end
        for (int k = 0; k < 64; k++) begin
            ed.push_back(mem[k]); et.push_back(8'h80 + 8'(k)); sum += mem[k];
        end
`ifdef DUMP_CHECKSUM_EN
        ed.push_back(sum); et.push_back(8'hFF);
`endif
        nexp = ed.size();

        @(negedge CLK); Start = 1'b1; OutReady = 1'b0;
        @(negedge CLK); s_edge = cyc; Start = 1'b0;
        got = 0; done_cnt = 0; done_edge = -1; after = 0; i = 0;
        prev_stall = 1'b0; busy_bad = 1'b0;
        p_data = '0; p_tag = '0; p_rr = '0; p_rm = '0;
        while (after < 5 && i < 1000) begin
            if (prev_stall) begin
                chk("stall_data", OutData, p_data);
                chk("stall_tag", OutTag, 32'(p_tag));
                chk("stall_readreg", 32'(ReadReg), 32'(p_rr));
                chk("stall_readmem", 32'(ReadMem), 32'(p_rm));
            end
            if (cyc == s_edge + 1) chk("reg_entry_valid", 32'(OutValid), 32'd0);
            if (cyc == s_edge + 2) begin
                chk("r0_valid", 32'(OutValid), 32'd1);
                chk("r0_tag", 32'(OutTag), 32'd0);
                chk("r0_data", OutData, regs[0]);
            end
            if (done_cnt == 1 && after == 1) chk("busy_drop", 32'(Busy), 32'd0);
            if (done_cnt == 0 && !Busy) busy_bad = 1'b1;
            if (Done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = cyc - s_edge;
            end
            if (done_cnt > 0) after++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (i % 4 == 0) || (i % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            OutReady = rdy;
            Start = poke && ((cyc == s_edge + 9) || Done);
            if (OutValid && rdy) begin
                if (got < nexp) begin
                    chk($sformatf("word%0d_data", got), OutData, ed[got]);
                    chk($sformatf("word%0d_tag", got), 32'(OutTag), 32'(et[got]));
                end
                last_data = OutData;
                last_tag  = OutTag;
                got++;
            end
            prev_stall = OutValid && !rdy;
            p_data = OutData; p_tag = OutTag; p_rr = ReadReg; p_rm = ReadMem;
            i++;
            @(negedge CLK);
        end
        Start = 1'b0; OutReady = 1'b0;
        chk("word_count", 32'(got), 32'(nexp));
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("busy_window", 32'(busy_bad), 32'd0);
        if (mode == 0) chk("done_edge", 32'(done_edge), 32'(nexp + 2));
        chk("end_busy", 32'(Busy), 32'd0);
        chk("end_valid", 32'(OutValid), 32'd0);
        $display("dump mode=%0d poke=%0d: %0d words, done at S+%0d", mode, poke, got, done_edge);
    endtask

    initial begin
        int s;
        for (int k = 0; k < 32; k++) regs[k] = 32'(k * 32'h11);
        for (int k = 0; k < 64; k++) mem[k]  = 32'h1000 + 32'(k);
        last_data = '0; last_tag = '0;

        repeat (3) @(negedge CLK);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_valid", 32'(OutValid), 32'd0);
        chk("rst_data", OutData, 32'd0);
        chk("rst_tag", 32'(OutTag), 32'd0);
        chk("rst_readreg", 32'(ReadReg), 32'd0);
        chk("rst_readmem", 32'(ReadMem), 32'd0);
        Reset = 1'b1;
        repeat (2) @(negedge CLK);
        chk("idle_valid", 32'(OutValid), 32'd0);
        chk("idle_busy", 32'(Busy), 32'd0);

        run_dump(0, 1'b0);
        run_dump(1, 1'b0);
        run_dump(0, 1'b1);

        // Abort a dump in progress with an asynchronous reset.
        @(negedge CLK); Start = 1'b1; OutReady = 1'b1;
        @(negedge CLK); s = cyc; Start = 1'b0;
        while (cyc < s + 40) @(negedge CLK);
        chk("pre_reset_busy", 32'(Busy), 32'd1);
        chk("pre_reset_valid", 32'(OutValid), 32'd1);
        Reset = 1'b0;
        #1;
        chk("abort_valid", 32'(OutValid), 32'd0);
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_done", 32'(Done), 32'd0);
        chk("abort_data", OutData, 32'd0);
        chk("abort_tag", 32'(OutTag), 32'd0);
        chk("abort_readmem", 32'(ReadMem), 32'd0);
        @(negedge CLK); Reset = 1'b1; OutReady = 1'b0;
        $display("reset abort at S+40 applied");

        for (int k = 0; k < 32; k++) regs[k] = $urandom;
        for (int k = 0; k < 64; k++) mem[k]  = $urandom;
        run_dump(2, 1'b0);
        run_dump(2, 1'b1);

`ifdef DUMP_CHECKSUM_EN
        for (int k = 0; k < 32; k++) regs[k] = 32'd1;
        for (int k = 0; k < 64; k++) mem[k]  = 32'd2;
        run_dump(0, 1'b0);
        chk("trailer_sum", last_data, 32'd160);
        chk("trailer_tag", 32'(last_tag), 32'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
